note_sequencer: RTL and testbench

Melody sequencer for the square-wave speaker path. It holds a small note table and plays it one entry at a time. For each entry it drives a clock-divider value and tone enable for a time measured in millisecond-scale ticks, then inserts an articulation gap. It sits between the control logic (table load, start/stop) and the square-wave tone generator that toggles the speaker pin.

---
 rtl/note_sequencer_if.sv | 29 ++
 rtl/note_sequencer.sv | 163 ++++++++++++++++
 tb/tb_note_sequencer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/note_sequencer_if.sv
// Control/table-load and tone-generator signals of the melody sequencer.
// The controller side is the master; the sequencer itself is the slave.
interface note_sequencer_if #(
  parameter int DIV_W  = 15,
  parameter int DUR_W  = 8,
  parameter int ADDR_W = 5
);
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DIV_W+DUR_W:0]     wr_data;
  logic                     start;
  logic                     stop;
  logic                     loop;
  logic                     busy;
  logic                     done;
  logic [DIV_W-1:0]         note_div;
  logic                     tone_en;
  logic [ADDR_W-1:0]        note_idx;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop, loop,
    input  busy, done, note_div, tone_en, note_idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, loop,
    output busy, done, note_div, tone_en, note_idx
  );
endinterface

// File: rtl/note_sequencer.sv
// Melody sequencer: plays a note table entry by entry, driving the divider and
// tone enable of the square-wave generator, with an articulation gap per note.
module note_sequencer #(
  parameter int TICK_DIV  = 12000,
  parameter int GAP_TICKS = 10,
  parameter int DIV_W     = 15,
  parameter int DUR_W     = 8,
  parameter int ADDR_W    = 5
) (
  input logic             clk,
  input logic             rst,
  note_sequencer_if.slave bus
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam int ENTRY_W = 1 + DIV_W + DUR_W;
  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W   = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam int CNT_W   = (DUR_W > GAP_W) ? DUR_W : GAP_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_PLAY  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t               state_r;
  logic [ENTRY_W-1:0]   mem_r [DEPTH];
  logic [ENTRY_W-1:0]   ram_q_r;
  logic [ADDR_W-1:0]    idx_r;
  logic                 last_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [PRESC_W-1:0]   presc_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 tone_en_r;
  logic [DIV_W-1:0]     note_div_r;

  logic                 q_last_s;
  logic [DIV_W-1:0]     q_div_s;
  logic [DUR_W-1:0]     q_dur_s;
  logic                 entry_last_s;
  logic                 tick_wrap_s;
  logic                 cnt_end_s;
  logic                 adv_now_s;
  logic                 adv_fetch_s;
  logic [ADDR_W-1:0]    adv_idx_s;

  // Note table: synchronous read, so a same-cycle write to the fetched address returns old data.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      mem_r[bus.wr_addr] <= bus.wr_data;
    end
    ram_q_r <= mem_r[idx_r];
  end

  // Entry decode, tick timing and where playback goes once the current entry is finished.
  always_comb begin
    q_last_s     = ram_q_r[ENTRY_W-1];
    q_div_s      = ram_q_r[DUR_W +: DIV_W];
    q_dur_s      = ram_q_r[DUR_W-1:0];
    entry_last_s = (state_r == ST_LOAD) ? q_last_s : last_r;
    tick_wrap_s  = (presc_r == PRESC_W'(TICK_DIV - 32'sd1));
    cnt_end_s    = tick_wrap_s && (cnt_r == CNT_W'(1));
    adv_now_s    = 1'b0;
    case (state_r)
      ST_LOAD: adv_now_s = (q_dur_s == {DUR_W{1'b0}});
      ST_PLAY: adv_now_s = cnt_end_s && (GAP_TICKS == 32'sd0);
      ST_GAP:  adv_now_s = cnt_end_s;
      default: adv_now_s = 1'b0;
    endcase
    if (!entry_last_s) begin
      adv_fetch_s = 1'b1;
      adv_idx_s   = idx_r + ADDR_W'(1);
    end else if (bus.loop) begin
      adv_fetch_s = 1'b1;
      adv_idx_s   = {ADDR_W{1'b0}};
    end else begin
      adv_fetch_s = 1'b0;
      adv_idx_s   = idx_r;
    end
  end

  // Playback FSM with registered outputs; stop beats both start and advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      idx_r      <= {ADDR_W{1'b0}};
      last_r     <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
      presc_r    <= {PRESC_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      tone_en_r  <= 1'b0;
      note_div_r <= {DIV_W{1'b0}};
    end else if (bus.stop && (state_r != ST_IDLE)) begin
      state_r    <= ST_IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      tone_en_r  <= 1'b0;
      note_div_r <= {DIV_W{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start && !bus.stop) begin
            state_r <= ST_FETCH;
            idx_r   <= {ADDR_W{1'b0}};
            busy_r  <= 1'b1;
          end
        end
        ST_FETCH: state_r <= ST_LOAD;
        ST_LOAD: begin
          last_r  <= q_last_s;
          presc_r <= {PRESC_W{1'b0}};
          cnt_r   <= CNT_W'(q_dur_s);
          if (!adv_now_s) begin
            state_r    <= ST_PLAY;
            note_div_r <= q_div_s;
            tone_en_r  <= (q_div_s != {DIV_W{1'b0}});
          end
        end
        ST_PLAY, ST_GAP: begin
          presc_r <= tick_wrap_s ? {PRESC_W{1'b0}} : presc_r + PRESC_W'(1);
          if (tick_wrap_s) begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
          if (cnt_end_s) begin
            note_div_r <= {DIV_W{1'b0}};
            tone_en_r  <= 1'b0;
          end
          // The same counter times the gap once the note itself has run out.
          if (cnt_end_s && (state_r == ST_PLAY) && (GAP_TICKS != 32'sd0)) begin
            state_r <= ST_GAP;
            cnt_r   <= CNT_W'(GAP_TICKS);
            presc_r <= {PRESC_W{1'b0}};
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          busy_r     <= 1'b0;
          tone_en_r  <= 1'b0;
          note_div_r <= {DIV_W{1'b0}};
        end
      endcase
      if (adv_now_s) begin
        state_r <= adv_fetch_s ? ST_FETCH : ST_IDLE;
        idx_r   <= adv_idx_s;
        busy_r  <= adv_fetch_s;
        done_r  <= !adv_fetch_s;
      end
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.tone_en  = tone_en_r;
  assign bus.note_div = note_div_r;
  assign bus.note_idx = idx_r;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: a note-level model expands each scenario
// into per-cycle expected outputs; a monitor pops and compares every cycle.
module tb_note_sequencer;

  localparam int TICK_DIV  = 4;
  localparam int GAP_TICKS = 1;
  localparam int DIV_W     = 15;
  localparam int DUR_W     = 8;
  localparam int ADDR_W    = 2;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int ENT_W     = 1 + DIV_W + DUR_W;
  localparam int MAXC      = 600;
  localparam int BIG       = 1 << 30;
  localparam int WDOG_CYC  = 20000;

  typedef struct {
    logic              busy;
    logic              done;
    logic              tone_en;
    logic [DIV_W-1:0]  div;
    logic [ADDR_W-1:0] idx;
    bit                chk_idx;
    int                cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  note_sequencer_if #(.DIV_W(DIV_W), .DUR_W(DUR_W), .ADDR_W(ADDR_W)) bus ();

  note_sequencer #(
    .TICK_DIV(TICK_DIV), .GAP_TICKS(GAP_TICKS), .DIV_W(DIV_W), .DUR_W(DUR_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t             exp_q[$];
  logic [ENT_W-1:0] tbl [DEPTH];
  int               total = 0;
  int               bad = 0;
  int               gen_cut = BIG;
  string            scen = "reset";
  bit               finished = 1'b0;

  function automatic logic [ENT_W-1:0] mk(input logic l, input int dv, input int du);
    return {l, DIV_W'(dv), DUR_W'(du)};
  endfunction

  function automatic void emit(input logic b, input logic d, input logic t,
                               input logic [DIV_W-1:0] dv, input int ix, input bit ck);
    exp_t r;
    if (exp_q.size() < gen_cut) begin
      r.busy = b; r.done = d; r.tone_en = t; r.div = dv;
      r.idx = ADDR_W'(ix); r.chk_idx = ck; r.cyc = exp_q.size();
      exp_q.push_back(r);
    end
  endfunction

  // Note-level reference: cycle 0 is the cycle in which start is sampled.
  // stop/rst asserted in cycle s make cycle s+1 idle; a write in cycle w is seen by fetches after w.
  function automatic int gen_trace(input bit lp, input int sc, input int rc, input int wc,
                                   input int wa, input logic [ENT_W-1:0] wd);
    int idx, fc, dur, pad_to;
    bit running, by_rst;
    logic [ENT_W-1:0] e;
    logic [DIV_W-1:0] dv;
    gen_cut = BIG;
    if (sc >= 0) gen_cut = sc + 1;
    if (rc >= 0 && rc + 1 < gen_cut) gen_cut = rc + 1;
    emit(1'b0, 1'b0, 1'b0, '0, 0, 1'b0);
    idx = 0;
    running = 1'b1;
    while (running && exp_q.size() < gen_cut && exp_q.size() < MAXC) begin
      fc = exp_q.size();
      emit(1'b1, 1'b0, 1'b0, '0, idx, 1'b1);
      emit(1'b1, 1'b0, 1'b0, '0, idx, 1'b1);
      e = (wc >= 0 && fc > wc && wa == idx) ? wd : tbl[idx];
      dv = e[DUR_W +: DIV_W];
      dur = int'(e[DUR_W-1:0]);
      if (dur != 0) begin
        for (int i = 0; i < dur * TICK_DIV; i++) emit(1'b1, 1'b0, (dv != '0), dv, idx, 1'b1);
        for (int i = 0; i < GAP_TICKS * TICK_DIV; i++) emit(1'b1, 1'b0, 1'b0, '0, idx, 1'b1);
      end
      if (!e[ENT_W-1]) idx = (idx + 1) % DEPTH;
      else if (lp) idx = 0;
      else running = 1'b0;
    end
    if (!running) emit(1'b0, 1'b1, 1'b0, '0, idx, 1'b0);
    by_rst = (rc >= 0) && (rc + 1 == gen_cut) && (exp_q.size() >= gen_cut);
    pad_to = exp_q.size() + 3;
    if (wc + 1 > pad_to) pad_to = wc + 1;
    if (sc + 1 > pad_to) pad_to = sc + 1;
    if (rc + 2 > pad_to) pad_to = rc + 2;
    gen_cut = BIG;
    while (exp_q.size() < pad_to) emit(1'b0, 1'b0, 1'b0, '0, 0, by_rst);
    return exp_q.size();
  endfunction

  task automatic load_table();
    for (int a = 0; a < DEPTH; a++) begin
      bus.wr_en = 1'b1;
      bus.wr_addr = ADDR_W'(a);
      bus.wr_data = tbl[a];
      @(posedge clk); #1;
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic run_scen(input string nm, input bit lp, input int sc, input int rc,
                          input int wc, input int wa, input logic [ENT_W-1:0] wd);
    int n;
    scen = nm;
    bus.loop = lp;
    n = gen_trace(lp, sc, rc, wc, wa, wd);
    for (int k = 0; k < n; k++) begin
      bus.start   = (k == 0);
      bus.stop    = (k == sc);
      rst         = (k == rc);
      bus.wr_en   = (k == wc);
      bus.wr_addr = ADDR_W'(wa);
      bus.wr_data = wd;
      @(posedge clk); #1;
    end
    bus.start = 1'b0; bus.stop = 1'b0; rst = 1'b0; bus.wr_en = 1'b0;
    if (wc >= 0) tbl[wa] = wd;
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (bus.busy !== e.busy || bus.done !== e.done || bus.tone_en !== e.tone_en ||
            bus.note_div !== e.div || (e.chk_idx && bus.note_idx !== e.idx)) begin
          bad++;
          $display("FAIL %s cyc %0d: got busy=%0b done=%0b tone_en=%0b note_div=%0d note_idx=%0d, want busy=%0b done=%0b tone_en=%0b note_div=%0d note_idx=%0d%s",
                   scen, e.cyc, bus.busy, bus.done, bus.tone_en, bus.note_div, bus.note_idx,
                   e.busy, e.done, e.tone_en, e.div, e.idx, e.chk_idx ? "" : "(idx unchecked)");
        end
      end
    end
  end

  // Watchdog: the whole run must finish within a bounded number of cycles.
  initial begin
    repeat (WDOG_CYC) @(posedge clk);
    if (!finished) begin
      bad++;
      $display("FAIL watchdog: test did not finish within %0d cycles (scen %s)", WDOG_CYC, scen);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    bit lp;
    int sc, rc, wc, wa;
    logic [ENT_W-1:0] wd;
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.loop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.tone_en !== 1'b0 ||
        bus.note_div !== '0 || bus.note_idx !== '0) begin
      bad++;
      $display("FAIL reset state: busy=%0b done=%0b tone_en=%0b note_div=%0d note_idx=%0d",
               bus.busy, bus.done, bus.tone_en, bus.note_div, bus.note_idx);
    end
    rst = 1'b0;
    gen_cut = BIG;
    for (int i = 0; i < 3; i++) emit(1'b0, 1'b0, 1'b0, '0, 0, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    tbl[0] = mk(1'b0, 100, 2); tbl[1] = mk(1'b0, 0, 1);
    tbl[2] = mk(1'b1, 200, 3); tbl[3] = mk(1'b1, 50, 1);
    load_table();
    run_scen("basic",      1'b0, -1, -1, -1, 0, '0);
    run_scen("loop",       1'b1, 60, -1, -1, 0, '0);
    run_scen("stop",       1'b0,  6, -1, -1, 0, '0);
    run_scen("start_stop", 1'b0,  0, -1, -1, 0, '0);
    run_scen("rst_play",   1'b0, -1,  5, -1, 0, '0);
    run_scen("wr_fetch",   1'b1, 75, -1, 15, 1, mk(1'b0, 555, 1));

    tbl[0] = mk(1'b0, 100, 1); tbl[1] = mk(1'b0, 300, 0);
    tbl[2] = mk(1'b1, 200, 1); tbl[3] = mk(1'b1, 7, 1);
    load_table();
    run_scen("skip", 1'b0, -1, -1, -1, 0, '0);

    for (int a = 0; a < DEPTH; a++) tbl[a] = mk(1'b0, 10 * (a + 1), 1);
    load_table();
    run_scen("wrap", 1'b0, 50, -1, -1, 0, '0);

    for (int r = 0; r < 12; r++) begin
      for (int a = 0; a < DEPTH; a++)
        tbl[a] = mk($urandom_range(0, 2) == 0, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 32767)),
                    int'($urandom_range(0, 3)));
      load_table();
      lp = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        rc = int'($urandom_range(3, 120)); sc = -1;
      end else begin
        sc = int'($urandom_range(10, 200)); rc = -1;
      end
      if ($urandom_range(0, 1) == 1) begin
        wc = int'($urandom_range(1, 40)); wa = int'($urandom_range(0, DEPTH - 1));
        wd = mk($urandom_range(0, 1) == 1, int'($urandom_range(0, 32767)), int'($urandom_range(0, 3)));
      end else begin
        wc = -1; wa = 0; wd = '0;
      end
      run_scen("random", lp, sc, rc, wc, wa, wd);
    end

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard: %0d expected records never compared", exp_q.size());
    end
    finished = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
